// File: rtl/axis_tone_sequencer.sv
// rtl/axis_tone_sequencer.sv - table-driven NCO step sequencer with a config stream
//
// Loads up to DEPTH {dwell, step} entries from s_axis_cfg (tlast closes a table).
// On start, it plays each step on m_axis_step for dwell cycles, with optional looping.
// Ports:
//   aclk, arst              clock, asynchronous active-high reset
//   s_axis_cfg_tdata        {dwell, step}, with step in the LSBs
//   s_axis_cfg_tvalid/tlast/tready  config handshake, ready only while idle
//   start, abort, loop_en   sampled control levels
//   m_axis_step_tdata/tvalid  step word and enable toward the NCO
//   busy, done, entry_idx   status
module axis_tone_sequencer #(
  parameter int ACC_WIDTH   = 32,
  parameter int DWELL_WIDTH = 32,
  parameter int DEPTH       = 8,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                             aclk,
  input  logic                             arst,
  input  logic [DWELL_WIDTH+ACC_WIDTH-1:0] s_axis_cfg_tdata,
  input  logic                             s_axis_cfg_tvalid,
  input  logic                             s_axis_cfg_tlast,
  output logic                             s_axis_cfg_tready,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             loop_en,
  output logic [ACC_WIDTH-1:0]             m_axis_step_tdata,
  output logic                             m_axis_step_tvalid,
  output logic                             busy,
  output logic                             done,
  output logic [IW-1:0]                    entry_idx
);

  // Wide enough to hold DEPTH itself (write pointer saturation, entry count).
  localparam int PW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          count_q, count_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [ACC_WIDTH-1:0]   tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   done_q, done_d;

  logic [ACC_WIDTH-1:0]   step_mem  [DEPTH];
  logic [DWELL_WIDTH-1:0] dwell_mem [DEPTH];

  logic          cfg_fire;
  logic          cfg_store;
  logic          can_start;
  logic          last_cycle;
  logic          last_entry;
  logic [IW-1:0] next_idx;

  assign s_axis_cfg_tready = (state_q == S_IDLE);
  assign cfg_fire          = s_axis_cfg_tvalid && s_axis_cfg_tready;
  assign cfg_store         = cfg_fire && (wr_ptr_q < PW'(DEPTH));
  assign can_start         = start && !abort && (count_q != '0);
  // dwell_cnt_q holds the remaining cycles minus one for the current entry.
  assign last_cycle        = (dwell_cnt_q == '0);
  assign last_entry        = (PW'(idx_q) == count_q - PW'(1));

  // A dwell of zero plays for one cycle, just like a dwell of one.
  function automatic logic [DWELL_WIDTH-1:0] dwell_load(input logic [DWELL_WIDTH-1:0] d);
    return (d == '0) ? '0 : d - DWELL_WIDTH'(1);
  endfunction

  // State register
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Abort wins over everything else.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (can_start) state_d = S_PLAY;
      S_PLAY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_cycle && last_entry && !loop_en) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    idx_d       = idx_q;
    dwell_cnt_d = dwell_cnt_q;
    tdata_d     = '0;
    tvalid_d    = 1'b0;
    done_d      = 1'b0;
    next_idx    = '0;

    // Beats past DEPTH are accepted but dropped; the pointer saturates at DEPTH.
    if (cfg_fire) begin
      if (cfg_store) wr_ptr_d = wr_ptr_q + PW'(1);
      if (s_axis_cfg_tlast) begin
        count_d  = cfg_store ? (wr_ptr_q + PW'(1)) : PW'(DEPTH);
        wr_ptr_d = '0;
      end
    end

    if (state_d == S_PLAY) begin
      tvalid_d = 1'b1;
      if (state_q == S_PLAY && !last_cycle) begin
        dwell_cnt_d = dwell_cnt_q - DWELL_WIDTH'(1);
        tdata_d     = tdata_q;
      end else begin
        // Entering PLAY, stepping to the next entry, or wrapping back to entry 0.
        if (state_q == S_PLAY && !last_entry) next_idx = idx_q + IW'(1);
        idx_d       = next_idx;
        dwell_cnt_d = dwell_load(dwell_mem[next_idx]);
        tdata_d     = step_mem[next_idx];
      end
    end else begin
      idx_d  = '0;
      done_d = (state_d == S_DONE);
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      dwell_cnt_q <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      done_q      <= done_d;
    end
  end

  // The table is not reset, and it ignores beats while reset is held.
  always_ff @(posedge aclk) begin
    if (!arst && cfg_store) begin
      step_mem[wr_ptr_q[IW-1:0]]  <= s_axis_cfg_tdata[ACC_WIDTH-1:0];
      dwell_mem[wr_ptr_q[IW-1:0]] <= s_axis_cfg_tdata[ACC_WIDTH +: DWELL_WIDTH];
    end
  end

  assign m_axis_step_tdata  = tdata_q;
  assign m_axis_step_tvalid = tvalid_q;
  assign done               = done_q;
  assign busy               = (state_q != S_IDLE);
  assign entry_idx          = (state_q == S_PLAY) ? idx_q : '0;

endmodule

// File: tb/tb_axis_tone_sequencer.sv
// tb/tb_axis_tone_sequencer.sv - directed and randomized checks of axis_tone_sequencer
module tb_axis_tone_sequencer;

  localparam int AW    = 32;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int IW    = 3;

  logic          aclk       = 1'b0;
  logic          arst       = 1'b1;
  logic [DW+AW-1:0] cfg_tdata = '0;
  logic          cfg_tvalid = 1'b0;
  logic          cfg_tlast  = 1'b0;
  logic          cfg_tready;
  logic          start      = 1'b0;
  logic          abort      = 1'b0;
  logic          loop_en    = 1'b0;
  logic [AW-1:0] step_tdata;
  logic          step_tvalid;
  logic          busy;
  logic          done;
  logic [IW-1:0] entry_idx;

  axis_tone_sequencer #(.ACC_WIDTH(AW), .DWELL_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk               (aclk),
    .arst               (arst),
    .s_axis_cfg_tdata   (cfg_tdata),
    .s_axis_cfg_tvalid  (cfg_tvalid),
    .s_axis_cfg_tlast   (cfg_tlast),
    .s_axis_cfg_tready  (cfg_tready),
    .start              (start),
    .abort              (abort),
    .loop_en            (loop_en),
    .m_axis_step_tdata  (step_tdata),
    .m_axis_step_tvalid (step_tvalid),
    .busy               (busy),
    .done               (done),
    .entry_idx          (entry_idx)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: a table, a beat counter, and a queue holding the
  // expanded per-cycle step sequence of the current pass.
  int unsigned m_step  [DEPTH];
  int          m_dwell [DEPTH];
  int          m_beats = 0;
  int          m_count = 0;
  int          m_mode  = 0;  // 0 idle, 1 playing, 2 done pulse
  bit          was_idle;
  int unsigned q_step[$];
  int          q_idx[$];
  logic [AW-1:0] e_tdata  = '0;
  logic          e_tvalid = 1'b0;
  logic          e_done   = 1'b0;
  int            e_idx    = 0;

  task automatic m_expand();
    for (int e = 0; e < m_count; e++) begin
      for (int c = 0; c < ((m_dwell[e] == 0) ? 1 : m_dwell[e]); c++) begin
        q_step.push_back(m_step[e]);
        q_idx.push_back(e);
      end
    end
  endtask

  task automatic m_pop();
    e_tdata  = q_step.pop_front();
    e_idx    = q_idx.pop_front();
    e_tvalid = 1'b1;
    e_done   = 1'b0;
  endtask

  task automatic m_clear();
    q_step.delete();
    q_idx.delete();
    e_tdata  = '0;
    e_tvalid = 1'b0;
    e_done   = 1'b0;
    e_idx    = 0;
  endtask

  initial forever begin
    @(posedge aclk or posedge arst);
    if (arst) begin
      m_beats = 0;
      m_count = 0;
      m_mode  = 0;
      m_clear();
    end else begin
      was_idle = (m_mode == 0);
      case (m_mode)
        0: if (start && !abort && m_count > 0) begin
          m_expand();
          m_pop();
          m_mode = 1;
        end
        1: begin
          if (abort) begin
            m_mode = 0;
            m_clear();
          end else if (q_step.size() > 0) begin
            m_pop();
          end else if (loop_en) begin
            m_expand();
            m_pop();
          end else begin
            m_mode = 2;
            m_clear();
            e_done = 1'b1;
          end
        end
        default: begin
          m_mode = 0;
          e_done = 1'b0;
        end
      endcase
      if (was_idle && cfg_tvalid) begin
        if (m_beats < DEPTH) begin
          m_step[m_beats]  = cfg_tdata[AW-1:0];
          m_dwell[m_beats] = int'(cfg_tdata[AW +: DW]);
        end
        m_beats++;
        if (cfg_tlast) begin
          m_count = (m_beats < DEPTH) ? m_beats : DEPTH;
          m_beats = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge aclk);
    chk("tvalid", step_tvalid, e_tvalid);
    chk("tdata", step_tdata, e_tdata);
    chk("done", done, e_done);
    chk("busy", busy, m_mode != 0);
    chk("entry_idx", entry_idx, (m_mode == 1) ? e_idx : 0);
    chk("cfg_tready", cfg_tready, m_mode == 0);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_beat(input int unsigned dwell, input int unsigned step, input bit last);
    cfg_tdata  = {DW'(dwell), AW'(step)};
    cfg_tvalid = 1'b1;
    cfg_tlast  = last;
    tick();
    cfg_tvalid = 1'b0;
    cfg_tlast  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_basic();
    send_beat(3, 85900, 1'b0);
    send_beat(2, 343600, 1'b1);
  endtask

  int unsigned basic_exp[5] = '{85900, 85900, 85900, 343600, 343600};
  int nb;
  int run_len;
  int n_high;

  initial begin
    // Reset state, and start while the table is empty
    repeat (3) tick();
    chk("rst_tvalid", step_tvalid, 0);
    chk("rst_tdata", step_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    arst  = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("empty_busy", busy, 0);
      chk("empty_tvalid", step_tvalid, 0);
    end
    start = 1'b0;
    tick();

    // Basic play
    load_basic();
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      chk("basic_tdata", step_tdata, basic_exp[k]);
      chk("basic_tvalid", step_tvalid, 1);
      tick();
    end
    chk("basic_done", done, 1);
    chk("basic_tvalid_end", step_tvalid, 0);
    tick();
    chk("basic_done_clr", done, 0);
    chk("basic_idle", busy, 0);

    // Loop and abort
    loop_en = 1'b1;
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      chk("loop_tdata", step_tdata, basic_exp[k % 5]);
      chk("loop_no_done", done, 0);
      tick();
    end
    abort = 1'b1;
    tick();
    abort   = 1'b0;
    loop_en = 1'b0;
    chk("abort_tvalid", step_tvalid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    tick();
    chk("abort_done2", done, 0);

    // Zero dwell
    send_beat(0, 1000, 1'b1);
    pulse_start();
    chk("zd_tdata", step_tdata, 1000);
    chk("zd_tvalid", step_tvalid, 1);
    tick();
    chk("zd_done", done, 1);
    chk("zd_tvalid_end", step_tvalid, 0);
    tick();

    // Table overflow
    for (int i = 1; i <= 10; i++) begin
      chk("ovf_tready", cfg_tready, 1);
      send_beat(1, i, i == 10);
    end
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      chk("ovf_tdata", step_tdata, k + 1);
      chk("ovf_idx", entry_idx, k);
      tick();
    end
    chk("ovf_done", done, 1);
    tick();

    // Maximum dwell plays without wrap-around
    send_beat(255, 77, 1'b1);
    pulse_start();
    n_high = 0;
    for (int c = 0; c < 300 && step_tvalid; c++) begin
      n_high++;
      tick();
    end
    chk("maxdwell_cycles", n_high, 255);
    chk("maxdwell_done", done, 1);
    tick();

    // Reset in the second cycle of PLAY
    load_basic();
    pulse_start();
    tick();
    arst = 1'b1;
    #1;
    chk("rstplay_tvalid", step_tvalid, 0);
    chk("rstplay_tdata", step_tdata, 0);
    chk("rstplay_busy", busy, 0);
    tick();
    tick();
    arst  = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("rstplay_restart_busy", busy, 0);
      chk("rstplay_no_done", done, 0);
    end
    start = 1'b0;
    tick();

    // Randomized tables, looping, aborts, stray starts and config beats
    for (int it = 0; it < 40; it++) begin
      nb = $urandom_range(1, 10);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send_beat($urandom_range(0, 4), $urandom, b == nb - 1);
      end
      loop_en = ($urandom_range(0, 2) == 0);
      pulse_start();
      run_len = $urandom_range(5, 60);
      for (int c = 0; c < run_len; c++) begin
        abort = ($urandom_range(0, 39) == 0);
        start = ($urandom_range(0, 7) == 0);
        if (!start && $urandom_range(0, 5) == 0) begin
          cfg_tvalid = 1'b1;
          cfg_tdata  = {DW'($urandom_range(0, 4)), AW'($urandom)};
          cfg_tlast  = ($urandom_range(0, 3) == 0);
        end else begin
          cfg_tvalid = 1'b0;
          cfg_tlast  = 1'b0;
        end
        if ($urandom_range(0, 15) == 0) loop_en = ~loop_en;
        tick();
      end
      start      = 1'b0;
      cfg_tvalid = 1'b0;
      cfg_tlast  = 1'b0;
      loop_en    = 1'b0;
      abort      = 1'b1;
      tick();
      abort = 1'b0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
